scc_mem_dump: RTL and testbench
===============================

SCC_MEM_DUMP -- requirements
Module: scc_mem_dump

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 32-bit data-memory words dumped.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address reported for word 0.
REQ-003 SHALL have parameter SKIP_ZERO, default 0, meaning 1 suppresses records whose data is 0.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port clk_en, input, 1, global enable; while it is 0, no state, counter or output changes.
REQ-007 SHALL have port halt_f, input, 1, CPU halt flag from scc_f25_top.
REQ-008 SHALL have port mem_rd_en, output, 1, data-memory read strobe.
REQ-009 SHALL have port mem_rd_addr, output, 32, word index to read, 0..DEPTH-1.
REQ-010 SHALL have port mem_rd_data, input, 32, read data, valid exactly one enabled cycle after mem_rd_en.
REQ-011 SHALL have ports rec_valid (output, 1), rec_ready (input, 1), rec_addr (output, 32, byte address) and rec_data (output, 32), forming a valid/ready record stream.
REQ-012 SHALL have ports dump_busy (output, 1) and dump_done (output, 1).

Function
REQ-013 SHALL implement FSM states IDLE, READ, WAIT, EMIT and DONE.
REQ-014 IDLE->READ SHALL occur on the first enabled cycle where halt_f=1 and the internal started flag is 0; the FSM then sets started and clears the index to 0.
REQ-015 READ SHALL assert mem_rd_en=1 with mem_rd_addr=index for one cycle, then go to WAIT.
REQ-016 WAIT SHALL capture mem_rd_data into rec_data and set rec_addr=BASE_ADDR+index*4.
REQ-017 From WAIT, the FSM SHALL go to EMIT, except that when SKIP_ZERO=1 and the data is 0 it SHALL skip EMIT and advance as in REQ-019.
REQ-018 In EMIT, rec_valid SHALL be 1; rec_addr and rec_data SHALL stay stable until a cycle with rec_valid&rec_ready, and rec_valid SHALL never drop without that handshake.
REQ-019 After the handshake or skip: if index==DEPTH-1, go to DONE; else increment the index and go to READ.
REQ-020 Throughput SHALL be at most one record per 3 enabled cycles, and the latency from the halt_f sample to the first rec_valid SHALL be 3 enabled cycles.
REQ-021 DONE SHALL hold dump_done=1 permanently until reset and SHALL ignore halt_f.
REQ-022 halt_f deasserting mid-dump SHALL NOT abort the dump; halt_f re-asserting after DONE SHALL NOT restart it.
REQ-023 dump_busy SHALL be 1 in READ, WAIT and EMIT, and 0 otherwise.
REQ-024 Index arithmetic SHALL be $clog2(DEPTH) bits wide with no wrap past DEPTH-1; rec_addr SHALL be computed in 32 bits, modulo 2^32.
REQ-025 When clk_en=0, rec_ready SHALL be ignored and no handshake SHALL complete.

Reset
REQ-026 While rst=1, the block SHALL be in IDLE with started=0, index=0, and mem_rd_en, mem_rd_addr, rec_valid, rec_addr, rec_data, dump_busy and dump_done all 0.
REQ-027 Reset asserted mid-dump SHALL abort immediately, with the next halt_f starting a fresh dump from index 0.

Structure
REQ-028 Package scc_dump_pkg SHALL hold the FSM state encoding, WORD_BYTES=4 and the record field widths.
REQ-029 The output holding register (rec_addr/rec_data/rec_valid with stall) SHALL be one sub-module, scc_dump_rec_reg; all other logic SHALL be inline.

Verification
REQ-030 DEPTH=128 with mem[100]=0x32 and rec_ready tied 1: raise halt_f -> exactly 128 records; the record with rec_addr=0x190 SHALL have rec_data=0x00000032; dump_done SHALL rise after the last record.
REQ-031 With SKIP_ZERO=1 and only mem[3]=0xDEADBEEF and mem[100]=0x32 nonzero: the bench SHALL see exactly 2 records, (0x00C,0xDEADBEEF) then (0x190,0x32).
REQ-032 rec_ready held 0 for 10 cycles during EMIT: rec_valid SHALL stay 1, the fields SHALL stay unchanged, and mem_rd_en SHALL stay 0.
REQ-033 With clk_en toggled 0/1 each cycle: the record sequence SHALL be identical to REQ-030 and the cycle count SHALL double.
REQ-034 Reset asserted at record 50, then halt_f re-raised: outputs SHALL be 0 during reset, and the dump SHALL restart at rec_addr=BASE_ADDR.
REQ-035 halt_f pulsed 1 cycle, and halt_f held after DONE: the dump SHALL complete exactly once, with no second record stream.

Source files
------------

// File: rtl/scc_dump_pkg.sv
// Shared definitions for the post-halt data-memory dump: FSM encoding,
// record field widths and the word-index to byte-address helper.
package scc_dump_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned REC_ADDR_W = 32;
  localparam int unsigned REC_DATA_W = 32;

  typedef logic [REC_ADDR_W-1:0] rec_addr_t;
  typedef logic [REC_DATA_W-1:0] rec_data_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    EMIT = 3'd3,
    DONE = 3'd4
  } dump_state_e;

  // Byte address of a word, wrapping modulo 2^32.
  function automatic rec_addr_t word_to_byte_addr(input rec_addr_t base, input rec_addr_t idx);
    return base + idx * rec_addr_t'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/scc_dump_rec_reg.sv
// Output holding register for the dump record stream: loads address/data
// from the read pipeline and holds them, valid included, until accepted.
module scc_dump_rec_reg
  import scc_dump_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_clk_en,
  input  logic      i_capture,
  input  logic      i_emit,
  input  rec_addr_t i_addr,
  input  rec_data_t i_data,
  input  logic      i_ready,
  output logic      o_valid,
  output rec_addr_t o_addr,
  output rec_data_t o_data,
  output logic      o_fire
);

  logic      r_valid;
  rec_addr_t r_addr;
  rec_data_t r_data;
  logic      w_fire;

  // A handshake only completes on an enabled cycle.
  assign w_fire = i_clk_en & r_valid & i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (i_clk_en) begin
      if (i_capture) begin
        r_addr  <= i_addr;
        r_data  <= i_data;
        r_valid <= i_emit;
      end else if (w_fire) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;
  assign o_data  = r_data;
  assign o_fire  = w_fire;

endmodule

// File: rtl/scc_mem_dump.sv
// Dumps DEPTH data-memory words as (byte address, data) records once after
// the CPU halts; runs exactly once per reset.
module scc_mem_dump
  import scc_dump_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter bit          SKIP_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        halt_f,
  output logic        mem_rd_en,
  output logic [31:0] mem_rd_addr,
  input  logic [31:0] mem_rd_data,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [31:0] rec_addr,
  output logic [31:0] rec_data,
  output logic        dump_busy,
  output logic        dump_done
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  dump_state_e   r_state;
  logic          r_started;
  logic [IW-1:0] r_index;
  logic          r_mem_rd_en;
  logic [31:0]   r_mem_rd_addr;
  logic          r_busy;
  logic          r_done;

  logic          w_skip;
  logic          w_capture;
  logic          w_fire;
  logic          w_advance;
  logic          w_last;
  logic [IW-1:0] w_next_index;
  rec_addr_t     w_rec_addr;

  assign w_skip       = SKIP_ZERO && (mem_rd_data == '0);
  assign w_capture    = clk_en && (r_state == WAIT);
  assign w_last       = (r_index == LAST_IDX);
  assign w_next_index = r_index + 1'b1;
  assign w_rec_addr   = word_to_byte_addr(BASE_ADDR, rec_addr_t'(r_index));
  // Leaving a word: either a skipped zero in WAIT or an accepted record.
  assign w_advance    = ((r_state == WAIT) && w_skip) || ((r_state == EMIT) && w_fire);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_started     <= 1'b0;
      r_index       <= '0;
      r_mem_rd_en   <= 1'b0;
      r_mem_rd_addr <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else if (clk_en) begin
      if (w_advance) begin
        if (w_last) begin
          r_state <= DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_index       <= w_next_index;
          r_state       <= READ;
          r_mem_rd_en   <= 1'b1;
          r_mem_rd_addr <= 32'(w_next_index);
        end
      end else begin
        case (r_state)
          IDLE: begin
            if (halt_f && !r_started) begin
              r_started     <= 1'b1;
              r_index       <= '0;
              r_state       <= READ;
              r_mem_rd_en   <= 1'b1;
              r_mem_rd_addr <= '0;
              r_busy        <= 1'b1;
            end
          end
          READ: begin
            r_mem_rd_en <= 1'b0;
            r_state     <= WAIT;
          end
          WAIT:    r_state <= EMIT;
          default: ;
        endcase
      end
    end
  end

  scc_dump_rec_reg u_rec_reg (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_clk_en  (clk_en),
    .i_capture (w_capture),
    .i_emit    (!w_skip),
    .i_addr    (w_rec_addr),
    .i_data    (mem_rd_data),
    .i_ready   (rec_ready),
    .o_valid   (rec_valid),
    .o_addr    (rec_addr),
    .o_data    (rec_data),
    .o_fire    (w_fire)
  );

  assign mem_rd_en   = r_mem_rd_en;
  assign mem_rd_addr = r_mem_rd_addr;
  assign dump_busy   = r_busy;
  assign dump_done   = r_done;

endmodule

// File: tb/tb_scc_mem_dump.sv
// Bench for scc_mem_dump: three configurations run side by side against a
// record list and cycle costs derived directly from memory contents.
module tb_scc_mem_dump;

  localparam int NDUT   = 3;
  localparam int MAXD   = 128;
  localparam int BUDGET = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b1;
  logic halt_f = 1'b0;
  logic rec_ready = 1'b0;

  logic        rd_en     [NDUT];
  logic [31:0] rd_addr   [NDUT];
  logic [31:0] rd_data   [NDUT];
  logic        rec_valid [NDUT];
  logic [31:0] rec_addr  [NDUT];
  logic [31:0] rec_data  [NDUT];
  logic        busy      [NDUT];
  logic        done      [NDUT];

  logic [31:0] mem   [NDUT][MAXD];
  int          dep   [NDUT];
  logic [31:0] base  [NDUT];
  bit          skipz [NDUT];
  logic [31:0] exp_a [NDUT][MAXD];
  logic [31:0] exp_d [NDUT][MAXD];
  int          exp_n [NDUT];
  int          cost  [NDUT];
  int          pre   [NDUT];

  int          got_n [NDUT];
  logic        pv    [NDUT];
  logic        pf    [NDUT];
  logic [31:0] pa    [NDUT];
  logic [31:0] pd    [NDUT];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  scc_mem_dump #(.DEPTH(128), .BASE_ADDR(32'h0000_0000), .SKIP_ZERO(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .halt_f(halt_f),
    .mem_rd_en(rd_en[0]), .mem_rd_addr(rd_addr[0]), .mem_rd_data(rd_data[0]),
    .rec_valid(rec_valid[0]), .rec_ready(rec_ready), .rec_addr(rec_addr[0]), .rec_data(rec_data[0]),
    .dump_busy(busy[0]), .dump_done(done[0])
  );

  scc_mem_dump #(.DEPTH(128), .BASE_ADDR(32'h0000_0000), .SKIP_ZERO(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .halt_f(halt_f),
    .mem_rd_en(rd_en[1]), .mem_rd_addr(rd_addr[1]), .mem_rd_data(rd_data[1]),
    .rec_valid(rec_valid[1]), .rec_ready(rec_ready), .rec_addr(rec_addr[1]), .rec_data(rec_data[1]),
    .dump_busy(busy[1]), .dump_done(done[1])
  );

  scc_mem_dump #(.DEPTH(100), .BASE_ADDR(32'hFFFF_FF80), .SKIP_ZERO(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .halt_f(halt_f),
    .mem_rd_en(rd_en[2]), .mem_rd_addr(rd_addr[2]), .mem_rd_data(rd_data[2]),
    .rec_valid(rec_valid[2]), .rec_ready(rec_ready), .rec_addr(rec_addr[2]), .rec_data(rec_data[2]),
    .dump_busy(busy[2]), .dump_done(done[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Synchronous-read memories: data appears one enabled cycle after the strobe.
  always @(posedge clk) begin
    for (int k = 0; k < NDUT; k++)
      if (clk_en && rd_en[k]) rd_data[k] <= mem[k][rd_addr[k][6:0]];
  end

  // Record scoreboard and stream-protocol monitor.
  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (rst) begin
        got_n[k] <= 0;
        pv[k]    <= 1'b0;
        pf[k]    <= 1'b0;
      end else begin
        if (pv[k] && !pf[k]) begin
          check($sformatf("d%0d_hold_valid", k), 32'(rec_valid[k]), 32'd1);
          check($sformatf("d%0d_hold_addr", k), rec_addr[k], pa[k]);
          check($sformatf("d%0d_hold_data", k), rec_data[k], pd[k]);
        end
        if (rec_valid[k]) check($sformatf("d%0d_rd_en_in_emit", k), 32'(rd_en[k]), 32'd0);
        if (rd_en[k]) check($sformatf("d%0d_rd_addr_range", k), 32'(rd_addr[k] < 32'(dep[k])), 32'd1);
        if (clk_en && rec_valid[k] && rec_ready) begin
          if (got_n[k] < exp_n[k]) begin
            check($sformatf("d%0d_rec%0d_addr", k, got_n[k]), rec_addr[k], exp_a[k][got_n[k]]);
            check($sformatf("d%0d_rec%0d_data", k, got_n[k]), rec_data[k], exp_d[k][got_n[k]]);
          end else begin
            check($sformatf("d%0d_extra_record", k), 32'(got_n[k] + 1), 32'(exp_n[k]));
          end
          got_n[k] <= got_n[k] + 1;
        end
        pv[k] <= rec_valid[k];
        pf[k] <= clk_en && rec_valid[k] && rec_ready;
        pa[k] <= rec_addr[k];
        pd[k] <= rec_data[k];
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("%s_d%0d_rd_en", tag, k), 32'(rd_en[k]), 32'd0);
      check($sformatf("%s_d%0d_rd_addr", tag, k), rd_addr[k], 32'd0);
      check($sformatf("%s_d%0d_valid", tag, k), 32'(rec_valid[k]), 32'd0);
      check($sformatf("%s_d%0d_addr", tag, k), rec_addr[k], 32'd0);
      check($sformatf("%s_d%0d_data", tag, k), rec_data[k], 32'd0);
      check($sformatf("%s_d%0d_busy", tag, k), 32'(busy[k]), 32'd0);
      check($sformatf("%s_d%0d_done", tag, k), 32'(done[k]), 32'd0);
    end
  endtask

  // Fresh memory images and the records / cycle costs they imply.
  task automatic prepare();
    for (int k = 0; k < NDUT; k++)
      for (int i = 0; i < MAXD; i++)
        case (k)
          0:       mem[k][i] = $urandom;
          1:       mem[k][i] = 32'd0;
          default: mem[k][i] = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
        endcase
    mem[0][100] = 32'h0000_0032;
    mem[1][3]   = 32'hDEAD_BEEF;
    mem[1][100] = 32'h0000_0032;
    for (int k = 0; k < NDUT; k++) begin
      exp_n[k] = 0;
      cost[k]  = 0;
      pre[k]   = 0;
      for (int i = 0; i < dep[k]; i++) begin
        if (skipz[k] && mem[k][i] == 32'd0) begin
          cost[k] += 2;
        end else begin
          exp_a[k][exp_n[k]] = base[k] + 32'(i) * 32'd4;
          exp_d[k][exp_n[k]] = mem[k][i];
          if (exp_n[k] == 0) pre[k] = cost[k];
          exp_n[k]++;
          cost[k] += 3;
        end
      end
    end
  endtask

  task automatic run_dump(input string name, input bit toggle, input bit stall, input int reset_at);
    int  n;
    int  first_v [NDUT];
    int  done_at [NDUT];
    bit  did_rst;
    bit  stalled;
    int  stall_left;
    int  final_n [NDUT];

    rst = 1'b1; halt_f = 1'b0; rec_ready = 1'b0; clk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero({name, "_rst"});
    prepare();
    rst = 1'b0;
    @(posedge clk);
    #1;
    halt_f = 1'b1; rec_ready = 1'b1;
    n = 0; did_rst = 0; stalled = 0; stall_left = 0;
    for (int k = 0; k < NDUT; k++) begin first_v[k] = 0; done_at[k] = 0; end

    while (n < BUDGET && !(done[0] && done[1] && done[2])) begin
      @(posedge clk);
      #1;
      n++;
      halt_f = 1'b0;
      for (int k = 0; k < NDUT; k++) begin
        if (first_v[k] == 0 && rec_valid[k]) first_v[k] = n;
        if (done_at[k] == 0 && done[k]) done_at[k] = n;
      end
      if (toggle) clk_en = ~clk_en;
      if (stall) begin
        if (stall_left > 0) begin
          rec_ready = 1'b0; stall_left--;
        end else if (!stalled && rec_valid[0] && got_n[0] == 5) begin
          rec_ready = 1'b0; stall_left = 9; stalled = 1;
        end else begin
          rec_ready = ($urandom_range(0, 2) != 0);
        end
      end
      if (reset_at > 0 && !did_rst && got_n[0] >= reset_at) begin
        did_rst = 1;
        rst = 1'b1;
        #1;
        check_outputs_zero({name, "_midrst_a"});
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero({name, "_midrst_b"});
        rst = 1'b0; halt_f = 1'b1; clk_en = 1'b1; rec_ready = 1'b1;
        n = 0;
        for (int k = 0; k < NDUT; k++) begin first_v[k] = 0; done_at[k] = 0; end
      end
    end

    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("%s_d%0d_done", name, k), 32'(done[k]), 32'd1);
      check($sformatf("%s_d%0d_busy_end", name, k), 32'(busy[k]), 32'd0);
      check($sformatf("%s_d%0d_rec_count", name, k), 32'(got_n[k]), 32'(exp_n[k]));
      if (!stall) begin
        check($sformatf("%s_d%0d_first_valid_cyc", name, k), 32'(first_v[k]),
              toggle ? 32'(2 * pre[k] + 5) : 32'(pre[k] + 3));
        check($sformatf("%s_d%0d_done_cyc", name, k), 32'(done_at[k]),
              toggle ? 32'(2 * cost[k] + 1) : 32'(cost[k] + 1));
      end
      final_n[k] = got_n[k];
    end

    // Halt held high after completion must not start a second stream.
    clk_en = 1'b1; halt_f = 1'b1; rec_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("%s_d%0d_no_restart", name, k), 32'(got_n[k]), 32'(final_n[k]));
      check($sformatf("%s_d%0d_done_held", name, k), 32'(done[k]), 32'd1);
      check($sformatf("%s_d%0d_busy_held", name, k), 32'(busy[k]), 32'd0);
    end
    halt_f = 1'b0;
  endtask

  initial begin
    dep[0] = 128; base[0] = 32'h0000_0000; skipz[0] = 1'b0;
    dep[1] = 128; base[1] = 32'h0000_0000; skipz[1] = 1'b1;
    dep[2] = 100; base[2] = 32'hFFFF_FF80; skipz[2] = 1'b0;
    for (int k = 0; k < NDUT; k++) exp_n[k] = 0;

    run_dump("base",   1'b0, 1'b0, 0);
    run_dump("toggle", 1'b1, 1'b0, 0);
    run_dump("stall",  1'b0, 1'b1, 0);
    run_dump("midrst", 1'b0, 1'b0, 50);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
